quad_angle_tracker: RTL and testbench
=====================================

# quad_angle_tracker

Parametrised synchronous successor to the hall-sensor angle tracker. Decodes the two motor hall/quadrature channels in x4 mode into a modulo-N shaft angle with direction, motion and fault reporting. Sits between the FPGA hall input pins and the position/monitor logic. All logic runs in a single clock domain, and asynchronous pin inputs are synchronised internally.

## Interface
Parameters:
- WIDTH, 12, angle register width.
- COUNTS_PER_REV, 4096, angle modulus. Legal range is 4..2**WIDTH; elaboration error outside this range.
- FILTER_LEN, 4, consecutive stable samples required to accept a new level on a channel (1..255).
- STALL_CYCLES, 1_000_000, cycles without a valid step before `moving` deasserts.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- hall_1  in  1  channel A pin, asynchronous.
- hall_2  in  1  channel B pin, asynchronous.
- zero  in  1  one-cycle pulse: set angle to 0.
- preset_valid  in  1  one-cycle pulse: load `preset_value`.
- preset_value  in  WIDTH  angle to load. Values ≥ COUNTS_PER_REV are reduced to COUNTS_PER_REV-1.
- clear_error  in  1  clears `error`.
- angle  out  WIDTH  current angle, 0..COUNTS_PER_REV-1.
- clockwise  out  1  direction of the last valid step (1 = clockwise).
- step  out  1  one-cycle pulse on each valid step.
- moving  out  1  a valid step occurred within the last STALL_CYCLES cycles.
- error  out  1  sticky flag: an illegal transition was seen.

## Operation
- Each channel passes through a 2-flop synchroniser, then a debounce filter. The filtered level changes only after the synchronised level has differed from it for FILTER_LEN consecutive cycles. Any bounce restarts the count.
- Filtered state {hall_1,hall_2} is decoded against its previous value:
  - Clockwise sequence: 00→10→11→01→00 (hall_1 leads). Each clockwise transition increments the angle.
  - The reverse sequence decrements the angle.
  - No change: hold.
  - Both bits changed: illegal. The angle holds, `step` stays low, and `error` sets.
- Wrap-around:
  - Incrementing from COUNTS_PER_REV-1 gives 0.
  - Decrementing from 0 gives COUNTS_PER_REV-1.
  - The arithmetic is WIDTH+1 bits wide with an explicit compare, not a natural overflow.
- Priority within a cycle is reset > zero > preset_valid > decoded step. A step coincident with zero or preset is discarded, and `step` stays low that cycle.
- `clockwise` updates only on a valid step and holds through stalls and illegal transitions.
- Stall counter:
  - Clears on each valid step and otherwise increments.
  - Saturates at STALL_CYCLES.
  - `moving` = (counter < STALL_CYCLES).
- `error` sets on an illegal transition and clears on `clear_error`. If both happen in the same cycle, set wins.
- Priming:
  - After reset, the first filtered sample is captured as the previous state without decoding.
  - The tracker therefore never counts a step caused by the pin level present at reset release.

## Timing
- Reset values: angle=0, clockwise=1, step=0, moving=0, error=0, filters and synchronisers cleared, primed=0, stall counter=STALL_CYCLES.
- Reset asserted mid-operation clears all state on the next clk edge, including any partially filtered edge.
- Pin-to-angle latency is FILTER_LEN+3 cycles, measured from the first clk edge that samples the new pin level. The breakdown is 2 cycles of synchroniser, FILTER_LEN cycles of filter and 1 cycle of decode register.
- `step` and `clockwise` update on the same edge as `angle`.
- zero and preset take effect on the edge that samples them, and `angle` is valid the following cycle.
- Maximum trackable rate is one channel transition per FILTER_LEN+1 cycles. Faster input can produce illegal transitions, which are flagged and not counted.

## Structure
- Package `quad_pkg` holds:
  - `typedef logic [1:0] quad_state_t`.
  - enum `quad_dir_e` {DIR_NONE, DIR_CW, DIR_CCW, DIR_ILLEGAL}.
  - function `quad_decode(prev, curr)` returning `quad_dir_e`.
- Sub-module `quad_input_filter` (synchroniser plus debounce, parameter FILTER_LEN) is instantiated once per channel.
- The top level contains the decode, angle, stall and error registers.

## Test plan
All scenarios use FILTER_LEN=4 unless stated otherwise.
- Reset, then 8 clockwise transitions with levels held for 10 cycles each, COUNTS_PER_REV=4096 → angle=8, clockwise=1, 8 `step` pulses. Each update lands FILTER_LEN+3=7 cycles after its pin change.
- COUNTS_PER_REV=1000, preset 999, 1 clockwise step → angle=0. Then 2 anticlockwise steps → angle=998, clockwise=0.
- A 3-cycle glitch on hall_1 → no step, angle unchanged, error=0. A 5-cycle pulse on the same channel → counted.
- Both pins toggled on the same edge → error=1, angle held. `clear_error` → error=0. Illegal transition and `clear_error` in the same cycle → error=1.
- A filtered step landing on the same edge as a `zero` pulse → angle=0, step=0. A `preset_valid` of 5000 with WIDTH=13 and COUNTS_PER_REV=4096 → angle=4095.
- Pins held at 11 through reset release → no step and angle=0. STALL_CYCLES=100 with no motion → moving=0. One step → moving=1 on the next cycle.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and the x4 quadrature transition decoder for the angle tracker.
package quad_pkg;

  typedef logic [1:0] quad_state_t;

  typedef enum logic [1:0] {DIR_NONE, DIR_CW, DIR_CCW, DIR_ILLEGAL} quad_dir_e;

  // State is {hall_1, hall_2}; clockwise order is 00 -> 10 -> 11 -> 01 -> 00.
  function automatic quad_dir_e quad_decode(quad_state_t prev, quad_state_t curr);
    quad_dir_e d;
    if (prev == curr)
      d = DIR_NONE;
    else if ((prev ^ curr) == 2'b11)
      d = DIR_ILLEGAL;
    else begin
      case ({prev, curr})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: d = DIR_CW;
        default:                                d = DIR_CCW;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser followed by a debounce filter that accepts a new level
// only after FILTER_LEN consecutive cycles of disagreement.
module quad_input_filter
  import quad_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  if (FILTER_LEN < 1 || FILTER_LEN > 255) begin : g_len_check
    $error("quad_input_filter: FILTER_LEN must be 1..255");
  end

  logic [1:0] sync;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] != level) begin
        if (cnt == 8'(FILTER_LEN - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= '0;  // any bounce back to the held level restarts the count
      end
    end
  end

endmodule

// File: rtl/quad_angle_tracker.sv
// x4 quadrature decoder producing a modulo-COUNTS_PER_REV shaft angle with
// direction, step, motion and sticky illegal-transition reporting.
module quad_angle_tracker
  import quad_pkg::*;
#(
  parameter int WIDTH          = 12,
  parameter int COUNTS_PER_REV = 4096,
  parameter int FILTER_LEN     = 4,
  parameter int STALL_CYCLES   = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hall_1,
  input  logic             hall_2,
  input  logic             zero,
  input  logic             preset_valid,
  input  logic [WIDTH-1:0] preset_value,
  input  logic             clear_error,
  output logic [WIDTH-1:0] angle,
  output logic             clockwise,
  output logic             step,
  output logic             moving,
  output logic             error
);

  if (COUNTS_PER_REV < 4 || COUNTS_PER_REV > (2 ** WIDTH)) begin : g_cpr_check
    $error("quad_angle_tracker: COUNTS_PER_REV must be 4..2**WIDTH");
  end

  localparam logic [WIDTH:0] CPR    = (WIDTH + 1)'(COUNTS_PER_REV);
  localparam logic [WIDTH:0] CPR_M1 = CPR - 1'b1;
  localparam int             SW     = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0]  STALL  = SW'(STALL_CYCLES);
  localparam logic [8:0]     WARM   = 9'(FILTER_LEN + 2);

  quad_state_t filt, prev;
  quad_dir_e   dir;
  logic        primed;
  logic [8:0]  warm;
  logic [SW-1:0] stall;
  logic [WIDTH:0] inc, dec, pre;

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .reset(reset), .pin(hall_1), .level(filt[1])
  );
  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .reset(reset), .pin(hall_2), .level(filt[0])
  );

  assign dir = primed ? quad_decode(prev, filt) : DIR_NONE;

  // Wrap handled by explicit compare in WIDTH+1 bits so COUNTS_PER_REV == 2**WIDTH works.
  assign inc = ({1'b0, angle} + 1'b1 == CPR) ? '0 : {1'b0, angle} + 1'b1;
  assign dec = (angle == '0) ? CPR_M1 : {1'b0, angle} - 1'b1;
  assign pre = ({1'b0, preset_value} >= CPR) ? CPR_M1 : {1'b0, preset_value};

  assign moving = (stall < STALL);

  always_ff @(posedge clk) begin
    if (reset) begin
      angle     <= '0;
      clockwise <= 1'b1;
      step      <= 1'b0;
      error     <= 1'b0;
      primed    <= 1'b0;
      warm      <= '0;
      prev      <= '0;
      stall     <= STALL;
    end else begin
      step <= 1'b0;
      // Prime only once the synchroniser and filter have flushed, so the pin
      // level present at reset release becomes the reference, not a step.
      if (!primed) begin
        if (warm == WARM) begin
          primed <= 1'b1;
          prev   <= filt;
        end else begin
          warm <= warm + 9'd1;
        end
      end else begin
        prev <= filt;
      end

      if (stall != STALL) stall <= stall + 1'b1;

      if (zero) begin
        angle <= '0;
      end else if (preset_valid) begin
        angle <= pre[WIDTH-1:0];
      end else if (dir == DIR_CW || dir == DIR_CCW) begin
        angle     <= (dir == DIR_CW) ? inc[WIDTH-1:0] : dec[WIDTH-1:0];
        clockwise <= (dir == DIR_CW);
        step      <= 1'b1;
        stall     <= '0;
      end

      if (dir == DIR_ILLEGAL) error <= 1'b1;
      else if (clear_error)   error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_angle_tracker.sv
// Directed bench: table of quadrature steps on two tracker configurations plus
// hand-written sequences for glitch, illegal, priority, priming and stall cases.
module tb_quad_angle_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, h1 = 1'b0, h2 = 1'b0;
  logic zero0 = 1'b0, pv0 = 1'b0, clr0 = 1'b0;
  logic [12:0] pval0 = '0;
  logic [12:0] angle0;
  logic cw0, step0, mov0, err0;
  logic zero1 = 1'b0, pv1 = 1'b0, clr1 = 1'b0;
  logic [9:0] pval1 = '0;
  logic [9:0] angle1;
  logic cw1, step1, mov1, err1;

  quad_angle_tracker #(.WIDTH(13), .COUNTS_PER_REV(4096), .FILTER_LEN(4), .STALL_CYCLES(100)) dut0 (
    .clk(clk), .reset(reset), .hall_1(h1), .hall_2(h2), .zero(zero0),
    .preset_valid(pv0), .preset_value(pval0), .clear_error(clr0),
    .angle(angle0), .clockwise(cw0), .step(step0), .moving(mov0), .error(err0)
  );

  quad_angle_tracker #(.WIDTH(10), .COUNTS_PER_REV(1000), .FILTER_LEN(4), .STALL_CYCLES(100)) dut1 (
    .clk(clk), .reset(reset), .hall_1(h1), .hall_2(h2), .zero(zero1),
    .preset_valid(pv1), .preset_value(pval1), .clear_error(clr1),
    .angle(angle1), .clockwise(cw1), .step(step1), .moving(mov1), .error(err1)
  );

  int tests = 0, fails = 0;
  int step_cnt0 = 0;
  always @(negedge clk) if (step0 === 1'b1) step_cnt0++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive pins and count cycles until dut0 reports a step (bounded).
  task automatic drive_wait(input logic [1:0] p, output int n);
    {h1, h2} = p;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (step0) break;
    end
  endtask

  typedef struct {
    logic [1:0] pins;
    logic       pre1;
    int         exp0;
    int         exp1;
    logic       cw;
  } row_t;

  row_t rows[11];
  int n, sc;

  initial begin
    rows[0]  = '{2'b10, 1'b0, 1, 1, 1'b1};
    rows[1]  = '{2'b11, 1'b0, 2, 2, 1'b1};
    rows[2]  = '{2'b01, 1'b0, 3, 3, 1'b1};
    rows[3]  = '{2'b00, 1'b0, 4, 4, 1'b1};
    rows[4]  = '{2'b10, 1'b0, 5, 5, 1'b1};
    rows[5]  = '{2'b11, 1'b0, 6, 6, 1'b1};
    rows[6]  = '{2'b01, 1'b0, 7, 7, 1'b1};
    rows[7]  = '{2'b00, 1'b0, 8, 8, 1'b1};
    rows[8]  = '{2'b10, 1'b1, 9, 0, 1'b1};    // dut1 preset 999 then wraps to 0
    rows[9]  = '{2'b00, 1'b0, 8, 999, 1'b0};
    rows[10] = '{2'b01, 1'b0, 7, 998, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_angle", angle0, 0);
    check("rst_cw", cw0, 1);
    check("rst_step", step0, 0);
    check("rst_moving", mov0, 0);
    check("rst_error", err0, 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);

    foreach (rows[i]) begin
      if (rows[i].pre1) begin
        pv1 = 1'b1; pval1 = 10'd999;
        @(negedge clk);
        pv1 = 1'b0;
        check("preset1", angle1, 999);
      end
      drive_wait(rows[i].pins, n);
      check($sformatf("latency[%0d]", i), n, 7);
      repeat (3) @(negedge clk);
      check($sformatf("angle0[%0d]", i), angle0, rows[i].exp0);
      check($sformatf("angle1[%0d]", i), angle1, rows[i].exp1);
      check($sformatf("cw0[%0d]", i), cw0, rows[i].cw);
      check($sformatf("cw1[%0d]", i), cw1, rows[i].cw);
    end
    check("step_count", step_cnt0, 11);
    check("no_error", err0, 0);

    // 3-cycle glitch is rejected, 5-cycle pulse is accepted (out and back)
    sc = step_cnt0;
    h1 = 1'b1; repeat (3) @(negedge clk); h1 = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch_steps", step_cnt0, sc);
    check("glitch_angle", angle0, 7);
    check("glitch_error", err0, 0);
    h1 = 1'b1; repeat (5) @(negedge clk); h1 = 1'b0;
    repeat (3) @(negedge clk);
    check("pulse_mid_angle", angle0, 6);
    repeat (12) @(negedge clk);
    check("pulse_steps", step_cnt0, sc + 2);
    check("pulse_angle", angle0, 7);

    // Illegal transition: both pins change together
    sc = step_cnt0;
    {h1, h2} = 2'b10;
    repeat (15) @(negedge clk);
    check("illegal_error", err0, 1);
    check("illegal_angle", angle0, 7);
    check("illegal_steps", step_cnt0, sc);
    check("illegal_cw_hold", cw0, 1);
    clr0 = 1'b1; @(negedge clk); clr0 = 1'b0;
    check("clear_error", err0, 0);
    {h1, h2} = 2'b01;
    repeat (6) @(negedge clk);
    clr0 = 1'b1; @(negedge clk); clr0 = 1'b0;
    check("set_beats_clear", err0, 1);
    repeat (5) @(negedge clk);

    // Step coincident with zero is discarded; oversize preset clamps
    sc = step_cnt0;
    {h1, h2} = 2'b00;
    repeat (6) @(negedge clk);
    zero0 = 1'b1; @(negedge clk); zero0 = 1'b0;
    check("zero_angle", angle0, 0);
    check("zero_step", step0, 0);
    @(negedge clk);
    check("zero_steps", step_cnt0, sc);
    pv0 = 1'b1; pval0 = 13'd5000; @(negedge clk); pv0 = 1'b0;
    check("preset_clamp", angle0, 4095);

    // Pins at 11 through reset release: no step; then stall timing
    reset = 1'b1;
    {h1, h2} = 2'b11;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sc = step_cnt0;
    repeat (20) @(negedge clk);
    check("prime_angle", angle0, 0);
    check("prime_steps", step_cnt0, sc);
    check("prime_error", err0, 0);
    check("stall_moving", mov0, 0);
    drive_wait(2'b01, n);
    check("stall_step_latency", n, 7);
    check("moving_after_step", mov0, 1);
    check("stall_step_angle", angle0, 1);
    repeat (99) @(negedge clk);
    check("moving_at_99", mov0, 1);
    @(negedge clk);
    check("moving_at_100", mov0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
